// File: rtl/regfile_dump_if.sv
// Output word stream of regfile_dump: valid/ready handshake carrying a data word, its register index and a last flag.
interface regfile_dump_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Streams registers FIRST_REG..NUM_REGS-1 out on a start pulse; REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum word (idx 32).
// Two cycles per word minimum (LOAD + SEND), first out_valid 2 cycles after start; a word is held until out_ready.
module regfile_dump #(
  parameter int NUM_REGS  = 32,
  parameter int FIRST_REG = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [4:0]     rf_raddr,
  input  logic [31:0]    rf_rdata,
  regfile_dump_if.master out,
  output logic           busy,
  output logic           done
);
  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, FIN} state_t;
  logic [31:0] checksum_q, checksum_d;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, FIN} state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        out_last_q, out_last_d;
  logic        hs;

  assign hs            = out_valid_q && out.out_ready;
  assign rf_raddr      = idx_q;
  assign out.out_valid = out_valid_q;
  assign out.out_data  = out_data_q;
  assign out.out_idx   = out_idx_q;
  assign out.out_last  = out_last_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          checksum_d = '0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        out_data_d  = rf_rdata;
        out_idx_d   = {1'b0, idx_q};
        out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          checksum_d  = checksum_q ^ out_data_q;
`endif
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FIN;
`endif
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      // First cycle here presents the folded checksum, then it is held like any word.
      CSUM: begin
        if (!out_valid_q) begin
          out_data_d  = checksum_q;
          out_idx_d   = 6'd32;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end else if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = FIN;
        end
      end
`endif
      FIN: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: full-range instance (32/0) and windowed instance (16/8).
module tb_regfile_dump;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];

  regfile_dump_if bus_a ();
  regfile_dump_if bus_b ();

  assign rdata_a = regs_a[raddr_a];
  assign rdata_b = regs_b[raddr_b];

  regfile_dump dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rf_raddr(raddr_a), .rf_rdata(rdata_a),
    .out(bus_a.master), .busy(busy_a), .done(done_a)
  );

  regfile_dump #(.NUM_REGS(16), .FIRST_REG(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rf_raddr(raddr_b), .rf_rdata(rdata_b),
    .out(bus_b.master), .busy(busy_b), .done(done_b)
  );

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic push_expected(input bit sel, input int first, input int num);
    logic [31:0] x;
    logic [31:0] d;
    word_t w;
    x = '0;
    for (int i = first; i < num; i++) begin
      d = sel ? regs_b[i] : regs_a[i];
      x ^= d;
      w.idx = 6'(i); w.data = d; w.last = !CS && (i == num - 1);
      exp_q.push_back(w);
    end
    if (CS) begin
      w.idx = 6'd32; w.data = x; w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one dump on the selected instance, checking every accepted word against the scoreboard.
  task automatic run_dump(input bit sel, input int ready_mode, input bit hold_start, input bit check_timing);
    int c, last_hs, first_valid;
    bit done_seen, prev_hold, rdy, v, l, dn, bz;
    logic [5:0]  ix, pix;
    logic [31:0] d, pd;
    logic [4:0]  ra;
    bit pl;
    word_t w;
    push_expected(sel, sel ? 8 : 0, sel ? 16 : 32);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    c = 0; last_hs = -1; first_valid = -1; done_seen = 0; prev_hold = 0;
    pix = '0; pd = '0; pl = 0;
    while (!done_seen && c < 600) begin
      @(negedge clk); c++;
      if (!hold_start) begin start_a = 1'b0; start_b = 1'b0; end
      v  = sel ? bus_b.out_valid : bus_a.out_valid;
      ix = sel ? bus_b.out_idx   : bus_a.out_idx;
      d  = sel ? bus_b.out_data  : bus_a.out_data;
      l  = sel ? bus_b.out_last  : bus_a.out_last;
      dn = sel ? done_b : done_a;
      ra = sel ? raddr_b : raddr_a;
      if (prev_hold) begin
        tests++;
        if ({v, ix, d, l} !== {1'b1, pix, pd, pl}) begin
          fails++;
          $display("FAIL hold_stable: valid=%b idx=%0d data=%h last=%b, required valid=1 idx=%0d data=%h last=%b", v, ix, d, l, pix, pd, pl);
        end
      end
      if (v && first_valid < 0) first_valid = c;
      if (dn) begin
        done_seen = 1;
        tests++;
        if (c != last_hs + 1 || exp_q.size() != 0) begin
          fails++;
          $display("FAIL done_timing: done at cycle %0d with %0d words pending, required cycle %0d with 0 pending", c, exp_q.size(), last_hs + 1);
        end
      end else begin
        rdy = (ready_mode == 0) ? 1'b1 : (c % 3 == 0);
        if (v) begin
          if (ix != 6'd32) begin
            tests++;
            if (ra !== ix[4:0]) begin
              fails++;
              $display("FAIL raddr: rf_raddr=%0d, required %0d", ra, ix[4:0]);
            end
          end
          if (rdy) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL extra_word: idx=%0d data=%h, required no further word", ix, d);
            end else begin
              w = exp_q.pop_front();
              if ({ix, d, l} !== {w.idx, w.data, w.last}) begin
                fails++;
                $display("FAIL word: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b", ix, d, l, w.idx, w.data, w.last);
              end
            end
            last_hs = c;
          end
        end
        prev_hold = v && !rdy;
        pix = ix; pd = d; pl = l;
        if (sel) bus_b.out_ready = rdy; else bus_a.out_ready = rdy;
      end
    end
    tests++;
    if (!done_seen) begin fails++; $display("FAIL timeout: no done within %0d cycles, required done", c); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL lost_words: %0d words never seen, required 0", exp_q.size()); end
    exp_q.delete();
    if (check_timing) begin
      tests++;
      if (first_valid != 2) begin fails++; $display("FAIL first_latency: %0d cycles, required 2", first_valid); end
      tests++;
      if (last_hs != (CS ? 66 : 64)) begin fails++; $display("FAIL dump_cycles: last handshake at %0d, required %0d", last_hs, CS ? 66 : 64); end
    end
    @(negedge clk);
    dn = sel ? done_b : done_a;
    bz = sel ? busy_b : busy_a;
    tests++;
    if (dn !== 1'b0 || bz !== 1'b0) begin
      fails++;
      $display("FAIL after_done: done=%b busy=%b, required done=0 busy=0", dn, bz);
    end
    if (hold_start) begin
      @(negedge clk);
      bz = sel ? busy_b : busy_a;
      v  = sel ? bus_b.out_valid : bus_a.out_valid;
      tests++;
      if (bz !== 1'b1 || v !== 1'b0) begin
        fails++;
        $display("FAIL restart_held: busy=%b valid=%b, required busy=1 valid=0", bz, v);
      end
      start_a = 1'b0; start_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    tests++;
    if ({bus_a.out_valid, bus_a.out_last, bus_a.out_data, bus_a.out_idx, raddr_a, busy_a, done_a} !== '0 ||
        {bus_b.out_valid, bus_b.out_last, bus_b.out_data, bus_b.out_idx, raddr_b, busy_b, done_b} !== '0) begin
      fails++;
      $display("FAIL reset_state: a valid=%b idx=%0d data=%h busy=%b done=%b; b valid=%b idx=%0d busy=%b, required all 0",
               bus_a.out_valid, bus_a.out_idx, bus_a.out_data, busy_a, done_a, bus_b.out_valid, bus_b.out_idx, busy_b);
    end
    do_reset();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 32; i++) regs_a[i] = '0;
    regs_a[5] = 32'h1;
    run_dump(0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    run_dump(0, 1, 0, 0);
  endtask

  task automatic test_checksum_pattern();
    for (int i = 0; i < 32; i++) regs_a[i] = '0;
    regs_a[1] = 32'hA5A5A5A5;
    regs_a[2] = 32'h0F0F0F0F;
    run_dump(0, 0, 0, 1);
  endtask

  task automatic test_start_held();
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    run_dump(0, 0, 1, 1);
    do_reset();
  endtask

  task automatic test_reset_abort();
    int c;
    bit hit;
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    start_a = 1'b1; c = 0; hit = 0;
    while (!hit && c < 200) begin
      @(negedge clk); c++;
      start_a = 1'b0;
      if (bus_a.out_valid && bus_a.out_idx == 6'd10) begin
        hit = 1; rst = 1'b1; bus_a.out_ready = 1'b0;
      end else begin
        bus_a.out_ready = 1'b1;
      end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL abort_reach: idx10 not presented in %0d cycles, required presented", c); end
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (bus_a.out_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: valid=%b busy=%b done=%b, required 0 0 0", bus_a.out_valid, busy_a, done_a);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (bus_a.out_valid !== 1'b0 || done_a !== 1'b0) begin
        fails++;
        $display("FAIL abort_quiet: valid=%b done=%b, required 0 0", bus_a.out_valid, done_a);
      end
    end
    run_dump(0, 0, 0, 1);
  endtask

  task automatic test_window();
    for (int i = 0; i < 32; i++) regs_b[i] = $urandom;
    run_dump(1, 1, 0, 0);
    for (int i = 0; i < 32; i++) regs_b[i] = $urandom;
    run_dump(1, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin regs_a[i] = '0; regs_b[i] = '0; end
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_checksum_pattern();
    test_start_held();
    test_reset_abort();
    test_window();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
